// File: rtl/sw_pe_affine.sv
// Affine-gap (Gotoh) Smith-Waterman / Needleman-Wunsch processing element.
// Holds one query symbol, scores one cell per enabled target symbol, and chains the best-score position downstream.
module sw_pe_affine #(
  parameter int SCORE_WIDTH = 12,
  parameter int BASE_WIDTH  = 2,
  parameter int POS_WIDTH   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic                   query_ld,
  input  logic [BASE_WIDTH-1:0]  query,
  input  logic [POS_WIDTH-1:0]   row_id,
  input  logic [SCORE_WIDTH-1:0] bnd_diag,
  input  logic [SCORE_WIDTH-1:0] bnd_left,
  input  logic [SCORE_WIDTH-1:0] match,
  input  logic [SCORE_WIDTH-1:0] mismatch,
  input  logic [SCORE_WIDTH-1:0] gap_open,
  input  logic [SCORE_WIDTH-1:0] gap_extend,
  input  logic                   en_in,
  input  logic                   last_in,
  input  logic [BASE_WIDTH-1:0]  data_in,
  input  logic [SCORE_WIDTH-1:0] h_in,
  input  logic [SCORE_WIDTH-1:0] f_in,
  input  logic [SCORE_WIDTH-1:0] best_in,
  input  logic [POS_WIDTH-1:0]   best_row_in,
  input  logic [POS_WIDTH-1:0]   best_col_in,
  output logic                   en_out,
  output logic                   last_out,
  output logic [BASE_WIDTH-1:0]  data_out,
  output logic [SCORE_WIDTH-1:0] h_out,
  output logic [SCORE_WIDTH-1:0] f_out,
  output logic [SCORE_WIDTH-1:0] best_out,
  output logic [POS_WIDTH-1:0]   best_row_out,
  output logic [POS_WIDTH-1:0]   best_col_out,
  output logic                   vld
);

  localparam logic [SCORE_WIDTH-1:0] ZERO   = {1'b1, {(SCORE_WIDTH-1){1'b0}}};
  localparam logic [BASE_WIDTH-1:0]  BASE_N = '1;
  localparam logic [POS_WIDTH-1:0]   COL_MAX = '1;

  typedef enum logic {S_WAIT, S_RUN} state_t;

  state_t state, state_nxt;

  logic                   mode_r;
  logic [BASE_WIDTH-1:0]  query_r;
  logic [SCORE_WIDTH-1:0] bnd_diag_r, bnd_left_r;
  logic [SCORE_WIDTH-1:0] diag_r, left_r, e_r;
  logic [POS_WIDTH-1:0]   col_r;
  logic [SCORE_WIDTH-1:0] run_best_r;
  logic [POS_WIDTH-1:0]   run_col_r;

  logic [SCORE_WIDTH-1:0] cell_diag, cell_left, cell_e;
  logic [POS_WIDTH-1:0]   cur_col, nxt_col;
  logic                   is_match;
  logic [SCORE_WIDTH-1:0] hd, e_new, f_new, h_raw, h_new;
  logic [SCORE_WIDTH-1:0] prev_best, own_best;
  logic [POS_WIDTH-1:0]   prev_col, own_col;

  function automatic logic [SCORE_WIDTH-1:0] sat_add(input logic [SCORE_WIDTH-1:0] a,
                                                     input logic [SCORE_WIDTH-1:0] b);
    logic [SCORE_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_WIDTH] ? '1 : sum[SCORE_WIDTH-1:0];
  endfunction

  function automatic logic [SCORE_WIDTH-1:0] sat_sub(input logic [SCORE_WIDTH-1:0] a,
                                                     input logic [SCORE_WIDTH-1:0] b);
    return (a < b) ? '0 : a - b;
  endfunction

  function automatic logic [SCORE_WIDTH-1:0] max2(input logic [SCORE_WIDTH-1:0] a,
                                                  input logic [SCORE_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) state <= S_WAIT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:  if (en_in && !last_in) state_nxt = S_RUN;
      S_RUN:   if (en_in && last_in)  state_nxt = S_WAIT;
      default: state_nxt = S_WAIT;
    endcase
  end

  // The first cell of a stream takes its neighbours from the latched boundaries instead of the running registers.
  always_comb begin
    cell_diag = (state == S_WAIT) ? bnd_diag_r : diag_r;
    cell_left = (state == S_WAIT) ? bnd_left_r : left_r;
    cell_e    = (state == S_WAIT) ? '0 : e_r;
    cur_col   = (state == S_WAIT) ? POS_WIDTH'(1) : col_r;
    nxt_col   = (cur_col == COL_MAX) ? COL_MAX : cur_col + POS_WIDTH'(1);
    prev_best = (state == S_WAIT) ? ZERO : run_best_r;
    prev_col  = (state == S_WAIT) ? '0 : run_col_r;

    is_match = (data_in == query_r) && (query_r != BASE_N) && (data_in != BASE_N);
    hd       = is_match ? sat_add(cell_diag, match) : sat_sub(cell_diag, mismatch);
    e_new    = max2(sat_sub(cell_left, gap_open), sat_sub(cell_e, gap_extend));
    f_new    = max2(sat_sub(h_in, gap_open), sat_sub(f_in, gap_extend));
    h_raw    = max2(hd, max2(e_new, f_new));
    h_new    = (!mode_r && h_raw < ZERO) ? ZERO : h_raw;

    // Strict compare so the earliest column keeps a tied best.
    own_best = (h_new > prev_best) ? h_new : prev_best;
    own_col  = (h_new > prev_best) ? cur_col : prev_col;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_r       <= 1'b0;
      query_r      <= '0;
      bnd_diag_r   <= ZERO;
      bnd_left_r   <= ZERO;
      diag_r       <= ZERO;
      left_r       <= ZERO;
      e_r          <= '0;
      col_r        <= '0;
      run_best_r   <= ZERO;
      run_col_r    <= '0;
      en_out       <= 1'b0;
      last_out     <= 1'b0;
      data_out     <= '0;
      h_out        <= ZERO;
      f_out        <= '0;
      best_out     <= ZERO;
      best_row_out <= '0;
      best_col_out <= '0;
      vld          <= 1'b0;
    end else begin
      en_out   <= 1'b0;
      last_out <= 1'b0;
      vld      <= 1'b0;
      if (state == S_WAIT && query_ld) begin
        query_r    <= query;
        mode_r     <= mode;
        bnd_diag_r <= bnd_diag;
        bnd_left_r <= bnd_left;
      end
      if (en_in) begin
        diag_r     <= h_in;
        left_r     <= h_new;
        e_r        <= e_new;
        col_r      <= nxt_col;
        run_best_r <= own_best;
        run_col_r  <= own_col;
        h_out      <= h_new;
        f_out      <= f_new;
        data_out   <= data_in;
        en_out     <= 1'b1;
        last_out   <= last_in;
        if (last_in) begin
          vld <= 1'b1;
          if (mode_r) begin
            best_out     <= h_new;
            best_row_out <= row_id;
            best_col_out <= cur_col;
          end else if (best_in >= own_best) begin
            best_out     <= best_in;
            best_row_out <= best_row_in;
            best_col_out <= best_col_in;
          end else begin
            best_out     <= own_best;
            best_row_out <= row_id;
            best_col_out <= own_col;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sw_pe_affine.sv
// Self-checking bench for sw_pe_affine: directed scenarios plus randomized streams
// scored by a plain-integer Gotoh reference model.
module tb_sw_pe_affine;
  localparam int SW = 12, BW = 2, PW = 10, ZERO = 2048, ROW = 1, SMAX = 4095;

  logic          clk = 1'b0;
  logic          rst, mode, query_ld, en_in, last_in;
  logic [BW-1:0] query, data_in, data_out;
  logic [PW-1:0] row_id, best_row_in, best_col_in, best_row_out, best_col_out;
  logic [SW-1:0] bnd_diag, bnd_left, match, mismatch, gap_open, gap_extend;
  logic [SW-1:0] h_in, f_in, best_in, h_out, f_out, best_out;
  logic          en_out, last_out, vld;

  always #5 clk = ~clk;

  sw_pe_affine #(.SCORE_WIDTH(SW), .BASE_WIDTH(BW), .POS_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .query_ld(query_ld), .query(query), .row_id(row_id),
    .bnd_diag(bnd_diag), .bnd_left(bnd_left), .match(match), .mismatch(mismatch),
    .gap_open(gap_open), .gap_extend(gap_extend), .en_in(en_in), .last_in(last_in),
    .data_in(data_in), .h_in(h_in), .f_in(f_in), .best_in(best_in),
    .best_row_in(best_row_in), .best_col_in(best_col_in), .en_out(en_out),
    .last_out(last_out), .data_out(data_out), .h_out(h_out), .f_out(f_out),
    .best_out(best_out), .best_row_out(best_row_out), .best_col_out(best_col_out), .vld(vld)
  );

  int total = 0, bad = 0;
  int n;
  int tgt[64], hin[64], fin[64], stall[64];
  int exp_h[64], exp_f[64], obs_h[64], obs_f[64];
  int exp_best, exp_brow, exp_bcol, obs_best, obs_brow, obs_bcol;

  task automatic check_output(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x < 0) ? 0 : (x > SMAX) ? SMAX : x;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reference: walk the row cell by cell with integer arithmetic and clamping.
  task automatic model(input int md, input int q, input int bd, input int bl,
                       input int bi, input int brw, input int bcl);
    int mt, mm, go, ge, diag, left, e, f, hd, h, best, bc, col, last_col, s;
    mt = int'(match); mm = int'(mismatch); go = int'(gap_open); ge = int'(gap_extend);
    diag = bd; left = bl; e = 0; best = ZERO; bc = 0; col = 1; h = 0; last_col = 1;
    for (int j = 0; j < n; j++) begin
      s    = (tgt[j] == q && q != 3) ? mt : -mm;
      hd   = sat(diag + s);
      e    = max2(sat(left - go), sat(e - ge));
      f    = max2(sat(hin[j] - go), sat(fin[j] - ge));
      h    = max2(hd, max2(e, f));
      if (md == 0 && h < ZERO) h = ZERO;
      exp_h[j] = h;
      exp_f[j] = f;
      if (h > best) begin best = h; bc = col; end
      diag = hin[j];
      left = h;
      last_col = col;
      col = (col < 1023) ? col + 1 : 1023;
    end
    if (md != 0) begin
      exp_best = h; exp_brow = ROW; exp_bcol = last_col;
    end else if (bi >= best) begin
      exp_best = bi; exp_brow = brw; exp_bcol = bcl;
    end else begin
      exp_best = best; exp_brow = ROW; exp_bcol = bc;
    end
  endtask

  task automatic load_query(input int md, input int q, input int bd, input int bl);
    query_ld = 1'b1; mode = md[0]; query = q[BW-1:0];
    bnd_diag = bd[SW-1:0]; bnd_left = bl[SW-1:0];
    @(posedge clk); #1;
    query_ld = 1'b0;
  endtask

  task automatic clear_stream();
    for (int j = 0; j < 64; j++) begin
      tgt[j] = 0; hin[j] = ZERO; fin[j] = 0; stall[j] = 0;
    end
  endtask

  task automatic run_stream(input int md, input int q, input int bd, input int bl,
                            input int bi, input int brw, input int bcl, input bit do_load);
    if (do_load) load_query(md, q, bd, bl);
    model(md, q, bd, bl, bi, brw, bcl);
    best_in = bi[SW-1:0]; best_row_in = brw[PW-1:0]; best_col_in = bcl[PW-1:0];
    for (int j = 0; j < n; j++) begin
      query_ld = 1'b0; en_in = 1'b1; last_in = (j == n - 1);
      data_in = tgt[j][BW-1:0]; h_in = hin[j][SW-1:0]; f_in = fin[j][SW-1:0];
      @(posedge clk); #1;
      en_in = 1'b0; last_in = 1'b0;
      obs_h[j] = int'(h_out);
      obs_f[j] = int'(f_out);
      check_output($sformatf("en_out[%0d]", j), int'(en_out), 1);
      check_output($sformatf("h_out[%0d]", j), int'(h_out), exp_h[j]);
      check_output($sformatf("f_out[%0d]", j), int'(f_out), exp_f[j]);
      check_output($sformatf("data_out[%0d]", j), int'(data_out), tgt[j]);
      check_output($sformatf("last_out[%0d]", j), int'(last_out), (j == n - 1) ? 1 : 0);
      check_output($sformatf("vld[%0d]", j), int'(vld), (j == n - 1) ? 1 : 0);
      if (j == n - 1) begin
        obs_best = int'(best_out); obs_brow = int'(best_row_out); obs_bcol = int'(best_col_out);
        check_output("best_out", obs_best, exp_best);
        check_output("best_row_out", obs_brow, exp_brow);
        check_output("best_col_out", obs_bcol, exp_bcol);
      end else begin
        // Stall cycles carry junk that must all be ignored, including a query reload.
        for (int k = 0; k < stall[j]; k++) begin
          last_in = 1'b1; data_in = BW'($urandom); h_in = SW'($urandom); f_in = SW'($urandom);
          query_ld = 1'b1; query = BW'($urandom); mode = 1'($urandom);
          bnd_diag = SW'($urandom); bnd_left = SW'($urandom);
          @(posedge clk); #1;
          query_ld = 1'b0; last_in = 1'b0;
          check_output($sformatf("stall en_out[%0d]", j), int'(en_out), 0);
          check_output($sformatf("stall h_out[%0d]", j), int'(h_out), exp_h[j]);
          check_output($sformatf("stall vld[%0d]", j), int'(vld), 0);
        end
      end
    end
    @(posedge clk); #1;
    check_output("vld pulse end", int'(vld), 0);
  endtask

  task automatic set_weights(input int mt, input int mm, input int go, input int ge);
    match = mt[SW-1:0]; mismatch = mm[SW-1:0]; gap_open = go[SW-1:0]; gap_extend = ge[SW-1:0];
  endtask

  task automatic scen1_stream();
    clear_stream();
    n = 3; tgt[0] = 2; tgt[1] = 0; tgt[2] = 0;
  endtask

  initial begin
    int md, q, bd, bl, bi, wide;
    rst = 1'b0; mode = 1'b0; query_ld = 1'b0; query = '0; row_id = PW'(ROW);
    bnd_diag = '0; bnd_left = '0; en_in = 1'b0; last_in = 1'b0; data_in = '0;
    h_in = '0; f_in = '0; best_in = '0; best_row_in = '0; best_col_in = '0;
    set_weights(2, 1, 3, 1);
    repeat (2) @(posedge clk);
    #1;
    check_output("rst en_out", int'(en_out), 0);
    check_output("rst h_out", int'(h_out), ZERO);
    check_output("rst best_out", int'(best_out), ZERO);
    check_output("rst f_out", int'(f_out), 0);
    check_output("rst vld", int'(vld), 0);
    rst = 1'b1;

    // Local scoring
    scen1_stream();
    run_stream(0, 0, ZERO, ZERO, ZERO, 5, 6, 1'b1);
    check_output("s1 h0", obs_h[0], 2048);
    check_output("s1 h1", obs_h[1], 2050);
    check_output("s1 h2", obs_h[2], 2050);
    check_output("s1 best", obs_best, 2050);
    check_output("s1 col", obs_bcol, 2);
    check_output("s1 row", obs_brow, 1);

    // Global scoring, single-cell stream
    clear_stream();
    n = 1; tgt[0] = 2; hin[0] = 2045;
    run_stream(1, 0, ZERO, 2045, 0, 0, 0, 1'b1);
    check_output("s2 h", obs_h[0], 2047);
    check_output("s2 f", obs_f[0], 2042);
    check_output("s2 best", obs_best, 2047);

    // Stall after the first symbol
    scen1_stream();
    stall[0] = 3;
    run_stream(0, 0, ZERO, ZERO, ZERO, 5, 6, 1'b1);
    check_output("s3 h2", obs_h[2], 2050);
    check_output("s3 best", obs_best, 2050);
    check_output("s3 col", obs_bcol, 2);

    // Saturation at both ends
    set_weights(100, 1, 3, 1);
    clear_stream();
    n = 1; tgt[0] = 0; hin[0] = 0; fin[0] = 0;
    run_stream(0, 0, 4090, ZERO, 0, 0, 0, 1'b1);
    check_output("s4 h sat", obs_h[0], 4095);
    check_output("s4 f floor", obs_f[0], 0);
    set_weights(2, 1, 3, 1);

    // Tie goes upstream
    scen1_stream();
    run_stream(0, 0, ZERO, ZERO, 2050, 7, 9, 1'b1);
    check_output("s5 tie row", obs_brow, 7);
    check_output("s5 tie col", obs_bcol, 9);

    // N never matches N
    clear_stream();
    n = 1; tgt[0] = 3;
    run_stream(0, 3, ZERO, ZERO, 0, 0, 0, 1'b1);
    check_output("s5 wildcard", obs_h[0], 2048);

    // Reset mid-run, then a stream using reset-state query/mode/boundaries
    load_query(1, 2, 100, 100);
    en_in = 1'b1; last_in = 1'b0; data_in = 2'd2; h_in = 12'd3000; f_in = 12'd0;
    repeat (2) @(posedge clk);
    #1;
    en_in = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check_output("s6 en_out", int'(en_out), 0);
    check_output("s6 last_out", int'(last_out), 0);
    check_output("s6 vld", int'(vld), 0);
    check_output("s6 data_out", int'(data_out), 0);
    check_output("s6 h_out", int'(h_out), ZERO);
    check_output("s6 f_out", int'(f_out), 0);
    check_output("s6 best_out", int'(best_out), ZERO);
    check_output("s6 best_row", int'(best_row_out), 0);
    check_output("s6 best_col", int'(best_col_out), 0);
    clear_stream();
    n = 2; tgt[0] = 0; tgt[1] = 0;
    run_stream(0, 0, ZERO, ZERO, 0, 0, 0, 1'b0);
    check_output("s6 fresh col", obs_bcol, 1);
    check_output("s6 fresh best", obs_best, 2050);

    // Randomized streams
    for (int t = 0; t < 30; t++) begin
      wide = (t % 5 == 4);
      set_weights($urandom_range(0, 20), $urandom_range(0, 12), $urandom_range(0, 12),
                  $urandom_range(0, 4));
      clear_stream();
      n = $urandom_range(1, 12);
      for (int j = 0; j < n; j++) begin
        tgt[j]   = $urandom_range(0, 3);
        hin[j]   = wide ? $urandom_range(0, SMAX) : $urandom_range(1950, 2200);
        fin[j]   = wide ? $urandom_range(0, SMAX) : $urandom_range(1900, 2150);
        stall[j] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      end
      md = $urandom_range(0, 1);
      q  = $urandom_range(0, 3);
      bd = wide ? $urandom_range(0, SMAX) : $urandom_range(1950, 2150);
      bl = wide ? $urandom_range(0, SMAX) : $urandom_range(1950, 2150);
      bi = $urandom_range(1950, 2250);
      run_stream(md, q, bd, bl, bi, $urandom_range(0, 1023), $urandom_range(0, 1023), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sw_pe_affine.md
# sw_pe_affine

Second-generation Smith-Waterman / Needleman-Wunsch processing element for the systolic alignment array. It holds one query symbol, streams target symbols and computes one cell per enabled cycle. Improvements over the first-generation PE:
- Gotoh affine gaps (separate E/F matrices).
- Local or global mode selectable at run time.
- Parametrised alphabet width with an N wildcard.
- Saturating biased arithmetic.
- Stall support.
- Best-score position tracking (row, column) chained through the array.

## Interface
- SCORE_WIDTH, 12: score width; scores biased, ZERO = 2**(SCORE_WIDTH-1).
- BASE_WIDTH, 2: symbol width (2 DNA, 5 protein); all-ones code = N wildcard.
- POS_WIDTH, 10: row/column index width.

Ports (clock `clk`, single clock; reset `rst`, synchronous, active-low):
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- mode  in  1  0 = local, 1 = global; sampled on query_ld.
- query_ld  in  1  load query and boundaries (ignored in RUN).
- query  in  BASE_WIDTH  query symbol for this row.
- row_id  in  POS_WIDTH  this PE's row index (static).
- bnd_diag, bnd_left  in  SCORE_WIDTH  H(i-1,0), H(i,0); sampled on query_ld.
- match, mismatch, gap_open, gap_extend  in  SCORE_WIDTH  unsigned magnitudes. match is added; the others are subtracted. gap_open is the total cost of the first gap symbol.
- en_in, last_in  in  1  symbol valid / final target symbol.
- data_in  in  BASE_WIDTH  target symbol.
- h_in, f_in  in  SCORE_WIDTH  H(i-1,j), F(i-1,j) from upstream.
- best_in  in  SCORE_WIDTH; best_row_in, best_col_in  in  POS_WIDTH  upstream result.
- en_out, last_out  out  1; data_out  out  BASE_WIDTH; h_out, f_out  out  SCORE_WIDTH.
- best_out  out  SCORE_WIDTH; best_row_out, best_col_out  out  POS_WIDTH.
- vld  out  1  one-cycle result pulse.

## Operation
- **States.** WAIT and RUN.
  - WAIT + query_ld: latch query, mode, bnd_diag, bnd_left.
  - WAIT + en_in: move to RUN; column counter set to 1; diagonal register = bnd_diag; left-H register = bnd_left; E register = 0.
  - RUN + en_in & last_in: compute the final cell, then return to WAIT.
  - RUN + !en_in: stall. All internal registers are held, en_out = 0, other outputs are held.
- **Per enabled cycle (cell i,j).** All ops saturate to [0, 2^SCORE_WIDTH-1].
  - s = (data_in == query and neither is N) ? +match : -mismatch.
  - Hd = diag + s.
  - E = max(Hleft - gap_open, E - gap_extend).
  - F = max(h_in - gap_open, f_in - gap_extend).
  - H = max(Hd, E, F). In local mode, H is additionally clamped to ≥ ZERO.
  - Register updates: diag <= h_in; Hleft <= H; h_out <= H; f_out <= F; data_out <= data_in; en_out <= 1; last_out <= last_in.
  - Column counter increments and saturates at 2^POS_WIDTH-1.
- **Best tracking, local mode.**
  - An internal running best/column is updated only on strict H > best, so the earliest column wins ties. It is initialised to ZERO/0 on entering RUN.
  - On the last cell: best_out = best_in if best_in ≥ own best (upstream wins ties), else own best. best_row_out/best_col_out follow the winner; own row = row_id.
- **Best tracking, global mode.** On the last cell: best_out = this cell's H, best_row_out = row_id, best_col_out = the column. best_in is ignored. The final PE therefore yields H(n,m).
- **vld.** Asserted exactly the cycle after en_in & last_in; cleared otherwise.
- **query_ld during RUN.** Ignored.
- **last_in with !en_in.** Ignored.

## Timing
- Latency: 1 cycle from en_in to en_out/h_out/f_out/data_out; best_out and vld are valid together with last_out.
- Back-to-back streams: a new en_in is legal the cycle after last_in (the PE is in WAIT).
- Reset (rst=0 at a clock edge), from any state including mid-RUN. Values after reset:
  - state = WAIT.
  - en_out = last_out = vld = 0, data_out = 0.
  - h_out = best_out = ZERO, f_out = 0.
  - best_row_out = best_col_out = 0.
  - query = 0, mode = local, column counter = 0.
  - bnd_diag = bnd_left = ZERO, E = 0.

## Test plan
Common settings for all scenarios: SCORE_WIDTH=12 (ZERO=2048), match=2, mismatch=1, gap_open=3, gap_extend=1, row_id=1.

1. **Local scoring.** Local, query A, bnd=2048, h_in=2048, f_in=0, best_in=2048, target G,A,A (last on A#2) -> h_out 2048, 2050, 2050; best_out 2050, best_col_out 2, best_row_out 1; vld one cycle with last_out.
2. **Global scoring.** Global, query A, bnd_diag=2048, bnd_left=2045, target G (last), h_in=2045, f_in=0 -> h_out 2047, f_out 2042, best_out 2047, vld=1.
3. **Stall.** Scenario 1 with en_in low for 3 cycles after G -> en_out low during the stall, h_out held at 2048; final results identical to scenario 1.
4. **Saturation.** Local, bnd_diag=4090, match=100, matching symbol -> h_out 4095; with h_in=0 and gap_open=3 -> f_out 0, with no wrap.
5. **Tie-break and wildcard.** best_in=2050 vs own best 2050 -> best_row_out = upstream row. query N vs data N -> mismatch applied (diag 2048 -> 2048 clamp).
6. **Reset mid-run.** rst low in RUN -> next cycle all outputs at reset values and state WAIT; the next en_in starts a fresh stream with column 1.
